// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, major opcodes,
// fetch FSM states, instruction buffer entry and an address helper.
package riscv_pkg;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // RV32I major opcodes (bits [6:0] of the instruction word)
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  // Fetch FSM: RUN issues requests, DRAIN swallows responses of a flushed stream
  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_t;

  // One instruction buffer entry
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  // Force an address onto a 32-bit word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small circular FIFO of {pc, ins} entries with
// synchronous flush. A push while full is accepted only if a pop frees
// a slot in the same cycle; the fetch unit never lets that be exceeded.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1'b1);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  // Circular pointer increment that also works for non-power-of-two depths
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? {AW{1'b0}} : p + AW'(1'b1);
  endfunction

  // Qualify push/pop against the current occupancy
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != FULL_C) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so the head never shows stale data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{pc: 32'h0000_0000, ins: NOP_INSTR};
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches to instruction memory,
// tracks outstanding requests, buffers in-order responses and hands the
// oldest one to decode. Redirects flush the buffer and drop responses that
// belong to the abandoned stream (DRAIN) before fetching resumes.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  fetch_state_t  state_r;
  fetch_state_t  state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_nxt_s;
  logic [31:0]   resp_pc_r;      // pc of the oldest live (non-discarded) request
  logic [31:0]   resp_pc_nxt_s;
  logic [CW-1:0] in_flight_r;
  logic [CW-1:0] in_flight_nxt_s;
  logic [CW-1:0] discard_r;
  logic [CW-1:0] discard_nxt_s;
  logic [CW-1:0] buf_count_s;
  logic          resp_ok_s;
  logic          budget_ok_s;
  logic          grant_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_data_s;

  // Request/response qualification; no request goes out in a redirect cycle
  always_comb begin
    resp_ok_s   = imem_rvalid && (in_flight_r != ZERO_C);
    budget_ok_s = ({1'b0, in_flight_r} + {1'b0, buf_count_s}) < {1'b0, DEPTH_C};
    imem_req    = rstn && (state_r == FETCH_RUN) && budget_ok_s && !redirect_valid;
    grant_s     = imem_req && imem_gnt;
    push_s      = resp_ok_s && (state_r == FETCH_RUN) && !redirect_valid;
    ins_valid   = (buf_count_s != ZERO_C);
    pop_s       = ins_valid && !stall && !redirect_valid;
    push_data_s = '{pc: resp_pc_r, ins: imem_rdata};
  end

  // Counter, PC and FSM next-state logic
  always_comb begin
    in_flight_nxt_s = in_flight_r;
    discard_nxt_s   = discard_r;
    fetch_pc_nxt_s  = fetch_pc_r;
    resp_pc_nxt_s   = resp_pc_r;
    state_nxt_s     = state_r;

    if (grant_s && !resp_ok_s) begin
      in_flight_nxt_s = in_flight_r + ONE_C;
    end else if (!grant_s && resp_ok_s) begin
      in_flight_nxt_s = in_flight_r - ONE_C;
    end else begin
      in_flight_nxt_s = in_flight_r;
    end

    case (state_r)
      FETCH_RUN: begin
        // Everything still outstanding after this cycle belongs to the old stream
        if (redirect_valid) begin
          discard_nxt_s = in_flight_nxt_s;
        end else begin
          discard_nxt_s = ZERO_C;
        end
      end
      FETCH_DRAIN: begin
        if (resp_ok_s && (discard_r != ZERO_C)) begin
          discard_nxt_s = discard_r - ONE_C;
        end else begin
          discard_nxt_s = discard_r;
        end
      end
      default: begin
        discard_nxt_s = ZERO_C;
      end
    endcase

    state_nxt_s = (discard_nxt_s != ZERO_C) ? FETCH_DRAIN : FETCH_RUN;

    if (redirect_valid) begin
      fetch_pc_nxt_s = word_align(redirect_pc);
      resp_pc_nxt_s  = word_align(redirect_pc);
    end else begin
      fetch_pc_nxt_s = grant_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
      resp_pc_nxt_s  = push_s  ? (resp_pc_r + 32'd4)  : resp_pc_r;
    end
  end

  // State register; reset abandons all outstanding fetches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= FETCH_RUN;
      fetch_pc_r  <= RESET_PC;
      resp_pc_r   <= RESET_PC;
      in_flight_r <= ZERO_C;
      discard_r   <= ZERO_C;
    end else begin
      state_r     <= state_nxt_s;
      fetch_pc_r  <= fetch_pc_nxt_s;
      resp_pc_r   <= resp_pc_nxt_s;
      in_flight_r <= in_flight_nxt_s;
      discard_r   <= discard_nxt_s;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head      (head_s),
    .count     (buf_count_s)
  );

  // Present the buffer head, or a NOP when nothing is buffered
  always_comb begin
    imem_addr = fetch_pc_r;
    if (ins_valid) begin
      ins    = head_s.ins;
      ins_pc = head_s.pc;
    end else begin
      ins    = NOP_INSTR;
      ins_pc = 32'h0000_0000;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries and max in-flight fetches.
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  decode hazard; hold current ins, do not pop.
REQ-006 redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-007 redirect_pc  input  32  new fetch address.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  in-order response valid.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 ins  output  32  instruction to control/decode.
REQ-014 ins_pc  output  32  address of ins.
REQ-015 ins_valid  output  1  ins holds a real fetched instruction.

Function
REQ-016 fetch_pc SHALL advance by 4 on each cycle with imem_req && imem_gnt; modulo-2^32 wrap (32'hFFFF_FFFC -> 0).
REQ-017 imem_addr SHALL equal fetch_pc; imem_req SHALL assert only in RUN and when in_flight + buf_count < BUF_DEPTH.
REQ-018 in_flight SHALL increment on grant, decrement on rvalid, both same cycle -> unchanged.
REQ-019 Each non-discarded response SHALL push {pc, rdata} into the buffer; pc tracked per in-flight slot, in order.
REQ-020 Latency: rvalid in cycle N -> ins/ins_valid visible cycle N+1; grant cycle 0 with rvalid cycle 1 -> ins cycle 2.
REQ-021 ins/ins_pc SHALL be the buffer head when ins_valid=1; when empty, ins SHALL be NOP 32'h0000_0013, ins_pc 0, ins_valid 0.
REQ-022 Pop SHALL occur when ins_valid && !stall; push and pop in same cycle SHALL both take effect, count unchanged.
REQ-023 stall=1 SHALL hold ins, ins_pc, ins_valid stable; fetch continues until buffer budget exhausted.
REQ-024 FSM states: RUN, DRAIN.
REQ-025 redirect_valid SHALL: flush buffer, set fetch_pc = {redirect_pc[31:2],2'b00}, ins_valid=0 next cycle, no grant counted that cycle.
REQ-026 On redirect, discard_cnt SHALL load in_flight minus any rvalid that cycle; if nonzero -> DRAIN, else stay RUN.
REQ-027 In DRAIN: imem_req=0, each rvalid decrements discard_cnt and is dropped; discard_cnt reaching 0 -> RUN next cycle.
REQ-028 Redirect during DRAIN SHALL update fetch_pc, keep discard_cnt accounting, remain DRAIN.
REQ-029 Redirect and stall same cycle: redirect wins, buffer flushed.
REQ-030 Redirect and push same cycle: pushed word discarded.
REQ-031 Buffer SHALL never overflow; rvalid with no in-flight request is a protocol error, ignored.

Reset
REQ-032 rstn low SHALL immediately force: fetch_pc=RESET_PC, state=RUN, in_flight=0, discard_cnt=0, buffer empty.
REQ-033 Under reset outputs SHALL be: imem_req=0, imem_addr=RESET_PC, ins=32'h0000_0013, ins_pc=0, ins_valid=0.
REQ-034 imem_req SHALL first assert in the first cycle after rstn deasserts.
REQ-035 Reset mid-operation SHALL abandon in-flight fetches; later responses ignored (in_flight=0).

Structure
REQ-036 Shared package riscv_pkg SHALL hold NOP_INSTR (32'h0000_0013), opcode constants, fetch FSM state enum.
REQ-037 Buffer SHALL be sub-module fetch_fifo: BUF_DEPTH entries of {pc[31:0], ins[31:0]}, push/pop/flush, count output.

Verification
REQ-038 Reset release, imem_gnt=1, rvalid one cycle after grant -> addr 0,4,8...; ins_valid first high cycle 2, ins_pc 0.
REQ-039 stall held 3 cycles with buffer full -> ins stable, imem_req=0, no pops; release -> next ins_pc +4.
REQ-040 Redirect to 32'h0000_0102 with 2 in flight -> DRAIN, two responses dropped, next imem_addr 32'h0000_0100.
REQ-041 fetch_pc 32'hFFFF_FFFC granted -> next imem_addr 32'h0000_0000.
REQ-042 Redirect+stall same cycle -> ins=32'h0000_0013, ins_valid=0 next cycle.
REQ-043 rstn asserted mid-DRAIN -> all outputs at reset values asynchronously; restart at RESET_PC.
